// File: rtl/alu_result_writeback_if.sv
// Register-file write port between the ALU write-back stage and the register file.
//   wr_valid : write request (master -> slave)
//   wr_addr  : write address (master -> slave)
//   wr_data  : write data    (master -> slave)
//   wr_ready : register file accepts the write this cycle (slave -> master)
// The address and data must not change while a request is waiting for wr_ready.
interface alu_result_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/alu_result_writeback.sv
// ALU result write-back stage.
// Captures the 64-bit ALU result into the Z register pair and derives the
// zero/negative flags. It then writes the result back to the register file
// through one valid/ready port. MUL/DIV results take two writes: first LO,
// then HI. Every other op takes one write to its destination register.
// Ports:
//   clk, clr           : clock, synchronous active-high reset
//   Chigh, Clow        : ALU result halves
//   Zin                : capture strobe
//   is_wide, wb_en     : op class and write-back enable, both sampled at capture
//   dest               : destination register for non-wide ops, sampled at capture
//   ZHighout, ZLowout  : readout select for bus_out (ZLowout wins)
//   bus_out            : combinational Z readout
//   wr                 : register-file write port (master side)
//   busy               : a write-back is in progress
//   flag_zero/flag_neg : flags of the last captured result
//   overrun            : sticky; set when Zin arrives while busy
//
// state  | meaning
// IDLE   | waiting for Zin
// WR_ONE | writing Zlow to the latched dest
// WR_LO  | writing Zlow to LO
// WR_HI  | writing Zhigh to HI
module alu_result_writeback #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int LO_ADDR = 17,
    parameter int HI_ADDR = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_W-1:0]     Chigh,
    input  logic [DATA_W-1:0]     Clow,
    input  logic                  Zin,
    input  logic                  is_wide,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     dest,
    input  logic                  ZHighout,
    input  logic                  ZLowout,
    output logic [DATA_W-1:0]     bus_out,
    alu_result_writeback_if.master wr,
    output logic                  busy,
    output logic                  flag_zero,
    output logic                  flag_neg,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, WR_ONE, WR_LO, WR_HI} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] zhigh_q, zhigh_d;
    logic [DATA_W-1:0] zlow_q, zlow_d;
    logic              flag_zero_q, flag_zero_d;
    logic              flag_neg_q, flag_neg_d;
    logic              overrun_q, overrun_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic accept;
    logic cap_zero;
    logic cap_neg;

    assign accept   = wr_valid_q & wr.wr_ready;
    // Wide ops judge the full 64-bit result; all others judge only the low half.
    assign cap_zero = is_wide ? ({Chigh, Clow} == '0) : (Clow == '0);
    assign cap_neg  = is_wide ? Chigh[DATA_W-1] : Clow[DATA_W-1];

    always_comb begin
        state_d     = state_q;
        zhigh_d     = zhigh_q;
        zlow_d      = zlow_q;
        flag_zero_d = flag_zero_q;
        flag_neg_d  = flag_neg_q;
        overrun_d   = overrun_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        // Any Zin outside IDLE is dropped. This includes the cycle of the final accept.
        if (Zin && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (Zin) begin
                    zhigh_d     = Chigh;
                    zlow_d      = Clow;
                    flag_zero_d = cap_zero;
                    flag_neg_d  = cap_neg;
                    if (wb_en) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = Clow;
                        if (is_wide) begin
                            state_d   = WR_LO;
                            wr_addr_d = ADDR_W'(LO_ADDR);
                        end else begin
                            state_d   = WR_ONE;
                            wr_addr_d = dest;
                        end
                    end
                end
            end
            WR_ONE: begin
                if (accept) begin
                    state_d    = IDLE;
                    wr_valid_d = 1'b0;
                end
            end
            WR_LO: begin
                if (accept) begin
                    state_d   = WR_HI;
                    wr_addr_d = ADDR_W'(HI_ADDR);
                    wr_data_d = zhigh_q;
                end
            end
            WR_HI: begin
                if (accept) begin
                    state_d    = IDLE;
                    wr_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                wr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            zhigh_q     <= '0;
            zlow_q      <= '0;
            flag_zero_q <= 1'b0;
            flag_neg_q  <= 1'b0;
            overrun_q   <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            zhigh_q     <= zhigh_d;
            zlow_q      <= zlow_d;
            flag_zero_q <= flag_zero_d;
            flag_neg_q  <= flag_neg_d;
            overrun_q   <= overrun_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus_out     = ZLowout ? zlow_q : (ZHighout ? zhigh_q : '0);
    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign busy        = (state_q != IDLE);
    assign flag_zero   = flag_zero_q;
    assign flag_neg    = flag_neg_q;
    assign overrun     = overrun_q;

endmodule
